// File: rtl/apb_regfile_completer.sv
// APB3 completer fronting a word-indexed register file; register 0 is a read-only ID word.
// Transfer takes 2+WAIT_CYCLES PCLK cycles, PREADY held low WAIT_CYCLES access cycles; PSELx low aborts.
module apb_regfile_completer #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 32,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(32'hA5B0_0001)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              setup;
  logic              in_err;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_blank;
  logic [DATA_W-1:0] rd_data;

  assign setup  = PSELx && !PENABLE;
  // Full-width compare: any high address bit makes the index out of range.
  assign in_err = (PADDR >= ADDR_W'(DEPTH)) || (PWRITE && (PADDR == '0));

  // With zero wait states READY is entered straight from the setup edge, so read the live bus.
  always_comb begin
    rd_addr  = addr_q;
    rd_blank = err_q || wr_q;
    if (state == S_IDLE) begin
      rd_addr  = PADDR;
      rd_blank = in_err || PWRITE;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!rd_blank) begin
      rd_data = (rd_addr == '0) ? ID_VALUE : regs[rd_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (setup) begin
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= in_err;
            cnt     <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= S_READY;
              PREADY  <= 1'b1;
              PSLVERR <= in_err;
              PRDATA  <= rd_data;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSELx) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt <= 4'd1) begin
            state   <= S_READY;
            cnt     <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= err_q;
            PRDATA  <= rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_READY: begin
          if (!PSELx || PENABLE) begin
            state   <= S_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            if (PSELx && wr_q && !err_q) regs[addr_q[IDX_W-1:0]] <= wdata_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: three builds (1, 3 and 0 wait states) against an array model.
module tb_apb_regfile_completer;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel [3];
  logic        pen [3];
  logic        pwr [3];
  logic [31:0] paddr [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [3][32];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  apb_regfile_completer #(.WAIT_CYCLES(1)) u_w1 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_regfile_completer #(.WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_regfile_completer #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[2]), .PENABLE(pen[2]), .PWRITE(pwr[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic int wcyc(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_models();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++) model[d][i] = 32'd0;
  endtask

  // Setup + access phases until PREADY is seen (bounded); leaves the bus driven.
  task automatic to_ready(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output int waits);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (pready[d] === 1'b1) break;
      waits++;
      if (waits > 40) break;
    end
  endtask

  task automatic xfer_chk(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
    int          w;
    logic [31:0] rd;
    logic        er;
    bit          e;
    to_ready(d, wr, a, wd, w);
    rd = prdata[d];
    er = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; pen[d] = 1'b0;
    e = (a >= 32'd32) || (wr && a == 32'd0);
    chk({tag, " pslverr"}, {31'd0, er}, {31'd0, e});
    chk({tag, " wait cycles"}, w, wcyc(d));
    chk({tag, " pready drop"}, {31'd0, pready[d]}, 32'd0);
    if (!wr) chk({tag, " prdata"}, rd, e ? 32'd0 : (a == 32'd0 ? ID : model[d][a[4:0]]));
    if (wr && !e) model[d][a[4:0]] = wd;
  endtask

  task automatic rand_run(input int d, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'd0;
        1:       a = 32'd32 + 32'($urandom_range(0, 40));
        2:       a = $urandom;
        default: a = 32'($urandom_range(1, 31));
      endcase
      xfer_chk(d, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rand d%0d a%h", d, a));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic release_reset();
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; pen[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_models();
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    clear_models();

    tbl[0]  = '{1'b1, 32'd31,         32'd69, 32'd0, 1'b0};
    tbl[1]  = '{1'b0, 32'd31,         32'd0,  32'd69, 1'b0};
    tbl[2]  = '{1'b1, 32'd29,         32'd9,  32'd0, 1'b0};
    tbl[3]  = '{1'b1, 32'd12,         32'd30, 32'd0, 1'b0};
    tbl[4]  = '{1'b1, 32'd3,          32'd2,  32'd0, 1'b0};
    tbl[5]  = '{1'b0, 32'd3,          32'd0,  32'd2, 1'b0};
    tbl[6]  = '{1'b0, 32'd12,         32'd0,  32'd30, 1'b0};
    tbl[7]  = '{1'b0, 32'd29,         32'd0,  32'd9, 1'b0};
    tbl[8]  = '{1'b1, 32'd0,          32'd5,  32'd0, 1'b1};
    tbl[9]  = '{1'b0, 32'd0,          32'd0,  ID,    1'b0};
    tbl[10] = '{1'b0, 32'd40,         32'd0,  32'd0, 1'b1};
    tbl[11] = '{1'b0, 32'h8000_0003,  32'd0,  32'd0, 1'b1};
    tbl[12] = '{1'b0, 32'd31,         32'd0,  32'd69, 1'b0};

    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset pready d%0d", d),  {31'd0, pready[d]},  32'd0);
      chk($sformatf("reset pslverr d%0d", d), {31'd0, pslverr[d]}, 32'd0);
      chk($sformatf("reset prdata d%0d", d),  prdata[d],           32'd0);
    end
    release_reset();

    // Directed table on the one-wait-state build.
    for (int i = 0; i < 13; i++) begin
      int          wt;
      logic [31:0] rd;
      logic        er;
      to_ready(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, wt);
      rd = prdata[0];
      er = pslverr[0];
      @(posedge clk); #1;
      psel[0] = 1'b0; pen[0] = 1'b0;
      chk($sformatf("tbl%0d pslverr", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d wait cycles", i), wt, 32'd1);
      if (!tbl[i].wr) chk($sformatf("tbl%0d prdata", i), rd, tbl[i].exp_rd);
      if (tbl[i].wr && !tbl[i].exp_err) model[0][tbl[i].addr[4:0]] = tbl[i].wdata;
    end

    // Setup with PENABLE already high from IDLE must be ignored.
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b0; paddr[0] = 32'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("protocol violation pready %0d", i), {31'd0, pready[0]}, 32'd0);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    xfer_chk(0, 1'b0, 32'd31, 32'd0, "after violation read");

    // Abort in WAIT, then abort in READY: neither may write.
    xfer_chk(0, 1'b1, 32'd6, 32'h1111, "abort prep write");
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 32'd6; pwdata[0] = 32'hCAFE;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort in wait pready", {31'd0, pready[0]}, 32'd0);
    @(posedge clk); #1;
    xfer_chk(0, 1'b0, 32'd6, 32'd0, "abort in wait readback");
    to_ready(0, 1'b1, 32'd6, 32'h2222, w);
    chk("abort in ready reached", {31'd0, pready[0]}, 32'd1);
    psel[0] = 1'b0; pen[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort in ready pready", {31'd0, pready[0]}, 32'd0);
    chk("abort in ready pslverr", {31'd0, pslverr[0]}, 32'd0);
    xfer_chk(0, 1'b0, 32'd6, 32'd0, "abort in ready readback");

    rand_run(0, 150);

    // Three-wait-state and zero-wait-state builds: back-to-back write/read of 7, then random.
    for (int d = 1; d < 3; d++) begin
      xfer_chk(d, 1'b1, 32'd7, 32'h1234_5678 + 32'(d), $sformatf("d%0d b2b write 7", d));
      xfer_chk(d, 1'b0, 32'd7, 32'd0,                  $sformatf("d%0d b2b read 7", d));
      xfer_chk(d, 1'b1, 32'd0, 32'd5,                  $sformatf("d%0d write id", d));
      rand_run(d, 60);
    end

    // Reset during the WAIT state of a write to 4.
    xfer_chk(0, 1'b1, 32'd4, 32'h0000_BEEF, "pre-reset write 4");
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 32'd4; pwdata[0] = 32'h0000_DEAD;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    @(negedge clk);
    chk("wait state pready", {31'd0, pready[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset in wait pready",  {31'd0, pready[0]},  32'd0);
    chk("reset in wait pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("reset in wait prdata",  prdata[0],           32'd0);
    release_reset();
    xfer_chk(0, 1'b0, 32'd4, 32'd0, "read 4 after reset");

    // Reset while READY is presenting read data, then while presenting an error.
    xfer_chk(0, 1'b1, 32'd31, 32'h0000_1234, "pre-reset write 31");
    to_ready(0, 1'b0, 32'd31, 32'd0, w);
    chk("ready prdata before reset", prdata[0], 32'h0000_1234);
    rst_n = 1'b0;
    #1;
    chk("reset in ready pready", {31'd0, pready[0]}, 32'd0);
    chk("reset in ready prdata", prdata[0],          32'd0);
    release_reset();
    to_ready(0, 1'b0, 32'd40, 32'd0, w);
    chk("ready pslverr before reset", {31'd0, pslverr[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset in ready pslverr", {31'd0, pslverr[0]}, 32'd0);
    release_reset();
    xfer_chk(0, 1'b0, 32'd31, 32'd0, "read 31 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
